// File: rtl/arm_reg_pkg.sv
// Shared definitions for the banked ARM7TDMI register file: mode encodings,
// CPSR bit positions, SPSR indexing and PSR merge helpers.
package arm_reg_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int CPSR_N       = 31;
  localparam int CPSR_Z       = 30;
  localparam int CPSR_C       = 29;
  localparam int CPSR_V       = 28;
  localparam int CPSR_I       = 7;
  localparam int CPSR_F       = 6;
  localparam int CPSR_T       = 5;
  localparam int CPSR_MODE_HI = 4;
  localparam int CPSR_MODE_LO = 0;

  localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

  localparam int N_PHYS  = 31;
  localparam int PHYS_W  = 5;
  localparam int N_SPSR  = 5;
  localparam logic [PHYS_W-1:0] PHYS_PC = 5'd15;

  typedef enum logic [2:0] {
    SPSR_FIQ  = 3'd0,
    SPSR_IRQ  = 3'd1,
    SPSR_SVC  = 3'd2,
    SPSR_ABT  = 3'd3,
    SPSR_UND  = 3'd4,
    SPSR_NONE = 3'd5
  } spsr_idx_e;

  typedef struct packed {
    logic [31:0] value;
    logic        err;
  } psr_merge_t;

  function automatic logic mode_legal(input logic [4:0] m);
    return (m == MODE_USR) || (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) ||
           (m == MODE_ABT) || (m == MODE_UND) || (m == MODE_SYS);
  endfunction

  function automatic spsr_idx_e spsr_of(input logic [4:0] m);
    case (m)
      MODE_FIQ: return SPSR_FIQ;
      MODE_IRQ: return SPSR_IRQ;
      MODE_SVC: return SPSR_SVC;
      MODE_ABT: return SPSR_ABT;
      MODE_UND: return SPSR_UND;
      default:  return SPSR_NONE;
    endcase
  endfunction

  // Byte-masked PSR update; a c byte carrying an illegal mode is kept whole.
  function automatic psr_merge_t psr_merge(input logic [31:0] old, input logic [31:0] wdata,
                                           input logic [3:0] mask);
    psr_merge_t r;
    r.value = old;
    r.err   = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r.value[8*b +: 8] = wdata[8*b +: 8];
    end
    if (mask[0] && !mode_legal(wdata[CPSR_MODE_HI:CPSR_MODE_LO])) begin
      r.value[7:0] = old[7:0];
      r.err        = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arm_bank_map.sv
// Maps (mode, architectural index, user override) onto one of the 31
// physical registers. Illegal modes give valid = 0 and index 0.
module arm_bank_map
  import arm_reg_pkg::*;
(
  input  logic [4:0]        mode,
  input  logic [3:0]        idx,
  input  logic              user,
  output logic [PHYS_W-1:0] phys,
  output logic              valid
);

  logic [4:0] m;
  logic [4:0] idx5;

  assign m    = user ? MODE_USR : mode;
  assign idx5 = {1'b0, idx};

  // Physical layout: 0-15 user/shared view, 16-22 FIQ R8-R14,
  // then R13/R14 pairs for IRQ (23), SVC (25), ABT (27), UND (29).
  always_comb begin
    phys  = idx5;
    valid = mode_legal(m);
    if (m == MODE_FIQ && idx >= 4'd8 && idx <= 4'd14) begin
      phys = 5'd8 + idx5;
    end else if (idx == 4'd13 || idx == 4'd14) begin
      case (m)
        MODE_IRQ: phys = 5'd10 + idx5;
        MODE_SVC: phys = 5'd12 + idx5;
        MODE_ABT: phys = 5'd14 + idx5;
        MODE_UND: phys = 5'd16 + idx5;
        default:  phys = idx5;
      endcase
    end
    if (!valid) phys = '0;
  end

endmodule

// File: rtl/arm_banked_regfile.sv
// ARM7TDMI register file with mode banking: 31 GPRs (R15 at physical 15),
// CPSR, five SPSRs, MSR/flag paths and single-edge exception entry/return.
module arm_banked_regfile
  import arm_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_RD   = 3,
  parameter int BYPASS = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*N_RD-1:0]      rd_addr,
  output logic [DATA_W*N_RD-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [3:0]             wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_user,
  input  logic                   pc_wr_en,
  input  logic [DATA_W-1:0]      pc_next,
  input  logic                   cpsr_wr_en,
  input  logic                   spsr_wr_en,
  input  logic [3:0]             psr_mask,
  input  logic [DATA_W-1:0]      psr_wdata,
  input  logic                   flags_wr_en,
  input  logic [3:0]             flags_in,
  input  logic                   exc_req,
  input  logic [4:0]             exc_mode,
  input  logic [DATA_W-1:0]      exc_vector,
  input  logic [DATA_W-1:0]      exc_lr,
  input  logic                   exc_ret,
  output logic [DATA_W-1:0]      pc_out,
  output logic [DATA_W-1:0]      cpsr_out,
  output logic [DATA_W-1:0]      spsr_out,
  output logic                   mode_err
);

  logic [DATA_W-1:0] gpr [N_PHYS];
  logic [31:0]       spsr [N_SPSR];
  logic [31:0]       cpsr;

  logic [4:0]        mode;
  spsr_idx_e         cur_spsr, exc_spsr;
  logic              has_spsr, exc_ok, gpr_we, wr_is_pc, err_next;
  logic [PHYS_W-1:0] wr_phys, exc_lr_phys;
  logic              wr_valid, exc_lr_valid;
  logic [31:0]       cur_spsr_val, exc_cpsr, msr_cpsr;
  logic [3:0]        cpsr_mask;
  psr_merge_t        msr_m, spsr_m, ret_m;

  assign mode     = cpsr[CPSR_MODE_HI:CPSR_MODE_LO];
  assign cur_spsr = spsr_of(mode);
  assign has_spsr = (cur_spsr != SPSR_NONE);
  assign exc_spsr = spsr_of(exc_mode);
  // Entering USR/SYS has no SPSR to save into, so it is rejected like an illegal mode.
  assign exc_ok   = exc_req && (exc_spsr != SPSR_NONE);

  arm_bank_map u_wr_map (.mode(mode), .idx(wr_addr), .user(wr_user),
                         .phys(wr_phys), .valid(wr_valid));
  arm_bank_map u_exc_map (.mode(exc_mode), .idx(4'd14), .user(1'b0),
                          .phys(exc_lr_phys), .valid(exc_lr_valid));

  assign gpr_we   = wr_en && wr_valid && !exc_req;
  assign wr_is_pc = gpr_we && (wr_phys == PHYS_PC);

  always_comb begin
    cur_spsr_val = '0;
    if (has_spsr) cur_spsr_val = spsr[cur_spsr];
  end

  assign cpsr_mask = (mode == MODE_USR) ? (psr_mask & 4'b1000) : psr_mask;
  assign msr_m     = psr_merge(cpsr, psr_wdata[31:0], cpsr_mask);
  assign spsr_m    = psr_merge(cur_spsr_val, psr_wdata[31:0], psr_mask);
  assign ret_m     = psr_merge(cpsr, cur_spsr_val, 4'b1111);

  always_comb begin
    msr_cpsr = msr_m.value;
    if (flags_wr_en && !cpsr_mask[3]) msr_cpsr[CPSR_N:CPSR_V] = flags_in;
  end

  always_comb begin
    exc_cpsr = cpsr;
    exc_cpsr[CPSR_MODE_HI:CPSR_MODE_LO] = exc_mode;
    exc_cpsr[CPSR_I] = 1'b1;
    exc_cpsr[CPSR_T] = 1'b0;
    if (exc_mode == MODE_FIQ || exc_mode == MODE_SVC) exc_cpsr[CPSR_F] = 1'b1;
  end

  always_comb begin
    err_next = 1'b0;
    if (exc_req) begin
      err_next = !exc_ok || !exc_lr_valid;
    end else begin
      if (spsr_wr_en && (!has_spsr || spsr_m.err)) err_next = 1'b1;
      if (exc_ret && (!has_spsr || ret_m.err)) err_next = 1'b1;
      if (!exc_ret && cpsr_wr_en && msr_m.err) err_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_PHYS; i++) gpr[i] <= '0;
      for (int i = 0; i < N_SPSR; i++) spsr[i] <= '0;
      cpsr     <= CPSR_RESET;
      mode_err <= 1'b0;
    end else begin
      mode_err <= err_next;
      if (exc_req) begin
        if (exc_ok) begin
          spsr[exc_spsr]   <= cpsr;
          gpr[exc_lr_phys] <= exc_lr;
          gpr[PHYS_PC]     <= exc_vector;
          cpsr             <= exc_cpsr;
        end
      end else begin
        if (gpr_we) gpr[wr_phys] <= wr_data;
        if (pc_wr_en && !wr_is_pc) gpr[PHYS_PC] <= pc_next;
        if (spsr_wr_en && has_spsr) spsr[cur_spsr] <= spsr_m.value;
        if (exc_ret) begin
          if (has_spsr) cpsr <= ret_m.value;
        end else if (cpsr_wr_en) begin
          cpsr <= msr_cpsr;
        end else if (flags_wr_en) begin
          cpsr[CPSR_N:CPSR_V] <= flags_in;
        end
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [PHYS_W-1:0] phys;
    logic              valid;
    logic [DATA_W-1:0] val;

    arm_bank_map u_rd_map (.mode(mode), .idx(rd_addr[4*k +: 4]), .user(1'b0),
                           .phys(phys), .valid(valid));

    always_comb begin
      val = valid ? gpr[phys] : '0;
      if (BYPASS != 0 && valid) begin
        if (exc_ok) begin
          if (phys == exc_lr_phys)  val = exc_lr;
          else if (phys == PHYS_PC) val = exc_vector;
        end else if (gpr_we && phys == wr_phys) begin
          val = wr_data;
        end
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = val;
  end

  assign pc_out = gpr[PHYS_PC];

  always_comb begin
    cpsr_out       = '0;
    cpsr_out[31:0] = cpsr;
    spsr_out       = '0;
    spsr_out[31:0] = cur_spsr_val;
  end

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Self-checking bench for arm_banked_regfile: one forwarding and one
// non-forwarding instance driven in lockstep.
module tb_arm_banked_regfile;

  localparam int W  = 32;
  localparam int NR = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [4*NR-1:0] rd_addr;
  logic [W*NR-1:0] rd1, rd0;
  logic            wr_en, wr_user, pc_wr_en, cpsr_wr_en, spsr_wr_en, flags_wr_en;
  logic            exc_req, exc_ret;
  logic [3:0]      wr_addr, psr_mask, flags_in;
  logic [4:0]      exc_mode;
  logic [W-1:0]    wr_data, pc_next, psr_wdata, exc_vector, exc_lr;
  logic [W-1:0]    pc1, cpsr1, spsr1, pc0, cpsr0, spsr0;
  logic            err1, err0;

  arm_banked_regfile #(.DATA_W(W), .N_RD(NR), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_user(wr_user),
    .pc_wr_en(pc_wr_en), .pc_next(pc_next), .cpsr_wr_en(cpsr_wr_en),
    .spsr_wr_en(spsr_wr_en), .psr_mask(psr_mask), .psr_wdata(psr_wdata),
    .flags_wr_en(flags_wr_en), .flags_in(flags_in), .exc_req(exc_req),
    .exc_mode(exc_mode), .exc_vector(exc_vector), .exc_lr(exc_lr), .exc_ret(exc_ret),
    .pc_out(pc1), .cpsr_out(cpsr1), .spsr_out(spsr1), .mode_err(err1));

  arm_banked_regfile #(.DATA_W(W), .N_RD(NR), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_user(wr_user),
    .pc_wr_en(pc_wr_en), .pc_next(pc_next), .cpsr_wr_en(cpsr_wr_en),
    .spsr_wr_en(spsr_wr_en), .psr_mask(psr_mask), .psr_wdata(psr_wdata),
    .flags_wr_en(flags_wr_en), .flags_in(flags_in), .exc_req(exc_req),
    .exc_mode(exc_mode), .exc_vector(exc_vector), .exc_lr(exc_lr), .exc_ret(exc_ret),
    .pc_out(pc0), .cpsr_out(cpsr0), .spsr_out(spsr0), .mode_err(err0));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]   wa;
    logic [W-1:0] wd;
    logic         user;
    logic [3:0]   ra;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[12];
  logic [W-1:0] sv_view[16];
  logic [W-1:0] us_view[16];

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string name, input logic [W-1:0] got);
    logic [W-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0x%08h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, e);
      end
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_user = 0;
    pc_wr_en = 0; pc_next = 0; cpsr_wr_en = 0; spsr_wr_en = 0;
    psr_mask = 0; psr_wdata = 0; flags_wr_en = 0; flags_in = 0;
    exc_req = 0; exc_mode = 0; exc_vector = 0; exc_lr = 0; exc_ret = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic msr(input logic [3:0] mask, input logic [W-1:0] data);
    cpsr_wr_en = 1; psr_mask = mask; psr_wdata = data;
    tick(); idle();
  endtask

  task automatic gpr_write(input logic [3:0] a, input logic [W-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick(); idle();
  endtask

  task automatic take_exc(input logic [4:0] m, input logic [W-1:0] lr, input logic [W-1:0] vec);
    exc_req = 1; exc_mode = m; exc_lr = lr; exc_vector = vec;
    tick(); idle();
  endtask

  function automatic logic [3:0] pick_reg();
    logic [3:0] r;
    r = 4'($urandom_range(0, 9));
    if (r > 4'd7) r = r + 4'd5;
    return r;
  endfunction

  initial begin
    idle();
    rd_addr = {4'd13, 4'd13, 4'd13};
    for (int i = 0; i < 16; i++) begin sv_view[i] = '0; us_view[i] = '0; end

    // Reset state
    tick(); tick();
    for (int k = 0; k < NR; k++) push('0);
    push(32'h0000_00D3); push('0); push('0); push('0);
    pop_check("rst_r13_p0", rd1[0 +: W]);
    pop_check("rst_r13_p1", rd1[W +: W]);
    pop_check("rst_r13_p2", rd1[2*W +: W]);
    pop_check("rst_cpsr", cpsr1);
    pop_check("rst_spsr", spsr1);
    pop_check("rst_pc", pc1);
    pop_check("rst_mode_err", {31'b0, err1});
    reset = 1;

    // Table-driven SVC writes, including LDM^-style user-bank writes of R13/R14
    for (int i = 0; i < 12; i++) begin
      vecs[i].wa   = pick_reg();
      vecs[i].wd   = $urandom;
      vecs[i].user = (vecs[i].wa >= 4'd13) ? 1'($urandom_range(0, 1)) : 1'b0;
      vecs[i].ra   = (i % 2 == 0) ? vecs[i].wa : pick_reg();
      if (vecs[i].user) us_view[vecs[i].wa] = vecs[i].wd;
      else              sv_view[vecs[i].wa] = vecs[i].wd;
      if (vecs[i].wa < 4'd13) us_view[vecs[i].wa] = vecs[i].wd;
      vecs[i].exp = sv_view[vecs[i].ra];
    end
    for (int i = 0; i < 12; i++) begin
      wr_en = 1; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_user = vecs[i].user;
      push(vecs[i].exp);
      tick(); idle();
      rd_addr[3:0] = vecs[i].ra;
      #1;
      pop_check($sformatf("vec%0d_rd", i), rd1[0 +: W]);
    end

    // SVC R13, then IRQ entry
    gpr_write(4'd13, 32'h1000);
    rd_addr = {4'd0, 4'd14, 4'd13};
    push(32'h1000);
    #1; pop_check("svc_r13", rd1[0 +: W]);
    push(32'h0); push(32'h24); push(32'h18); push(32'hD3); push(32'hD2);
    take_exc(5'b10010, 32'h24, 32'h18);
    pop_check("irq_r13", rd1[0 +: W]);
    pop_check("irq_r14", rd1[W +: W]);
    pop_check("irq_pc", pc1);
    pop_check("irq_spsr", spsr1);
    pop_check("irq_cpsr", cpsr1);

    // Return from IRQ restores SVC banking
    push(32'hD3); push(32'h1000); push(32'h0);
    exc_ret = 1; tick(); idle();
    pop_check("ret_cpsr", cpsr1);
    pop_check("ret_r13", rd1[0 +: W]);
    pop_check("ret_mode_err", {31'b0, err1});

    // FIQ banking of R8, then drop to USR
    msr(4'b0001, 32'hD1);
    gpr_write(4'd8, 32'hAA);
    rd_addr[3:0] = 4'd8;
    push(32'hAA); #1; pop_check("fiq_r8", rd1[0 +: W]);
    push(32'h10); push(32'h0); push(32'h0);
    msr(4'b0001, 32'h10);
    pop_check("usr_cpsr", cpsr1);
    pop_check("usr_r8", rd1[0 +: W]);
    pop_check("usr_spsr", spsr1);
    push(32'hF000_0010);
    msr(4'b1111, 32'hF000_0000);
    pop_check("usr_f_byte", cpsr1);
    push(32'hF000_0010);
    msr(4'b0001, 32'h13);
    pop_check("usr_msr_mode_blocked", cpsr1);
    push(32'h1); push(32'h0);
    spsr_wr_en = 1; psr_mask = 4'b1111; psr_wdata = 32'h1234_5678;
    tick(); idle();
    pop_check("usr_spsr_wr_err", {31'b0, err1});
    tick();
    pop_check("usr_err_pulse_end", {31'b0, err1});

    // SVC entry from USR, then SYS
    push(32'hF000_00D3); push(32'hF000_0010); push(32'h8);
    take_exc(5'b10011, 32'h8, 32'h8);
    pop_check("svc_exc_cpsr", cpsr1);
    pop_check("svc_exc_spsr", spsr1);
    pop_check("svc_exc_pc", pc1);
    push(32'hF000_00DF); push(32'h0); push(us_view[13]);
    rd_addr[3:0] = 4'd13;
    msr(4'b0001, 32'hDF);
    pop_check("sys_cpsr", cpsr1);
    pop_check("sys_spsr", spsr1);
    pop_check("sys_r13_user_bank", rd1[0 +: W]);
    push(32'h1); push(32'hF000_00DF);
    exc_ret = 1; tick(); idle();
    pop_check("sys_ret_err", {31'b0, err1});
    pop_check("sys_ret_cpsr", cpsr1);

    // Illegal mode via MSR and via exception
    push(32'h1); push(32'h3000_00DF);
    msr(4'b1001, 32'h3000_0015);
    pop_check("msr_illegal_err", {31'b0, err1});
    pop_check("msr_illegal_cpsr", cpsr1);
    push(32'h1); push(32'h3000_00DF); push(32'h8);
    take_exc(5'b10100, 32'h11, 32'h44);
    pop_check("exc_illegal_err", {31'b0, err1});
    pop_check("exc_illegal_cpsr", cpsr1);
    pop_check("exc_illegal_pc", pc1);

    // Flag updates and MSR-f priority
    push(32'h5000_00DF);
    flags_wr_en = 1; flags_in = 4'b0101; tick(); idle();
    pop_check("flags", cpsr1);
    push(32'h8000_00DF);
    flags_wr_en = 1; flags_in = 4'hF; cpsr_wr_en = 1; psr_mask = 4'b1000;
    psr_wdata = 32'h8000_0000;
    tick(); idle();
    pop_check("flags_vs_msr", cpsr1);

    // Same-cycle write/read forwarding
    rd_addr[3:0] = 4'd3;
    wr_en = 1; wr_addr = 4'd3; wr_data = 32'h55;
    push(32'h55); push(sv_view[3]);
    #1;
    pop_check("byp_r3", rd1[0 +: W]);
    pop_check("nobyp_r3", rd0[0 +: W]);
    push(32'h55); push(32'h55);
    tick(); idle();
    pop_check("r3_after", rd1[0 +: W]);
    pop_check("nb_r3_after", rd0[0 +: W]);

    // PC update port and R15 write priority
    push(32'h100);
    pc_wr_en = 1; pc_next = 32'h100; tick(); idle();
    pop_check("pc_wr", pc1);
    push(32'h200);
    pc_wr_en = 1; pc_next = 32'h300; wr_en = 1; wr_addr = 4'd15; wr_data = 32'h200;
    tick(); idle();
    pop_check("r15_wins", pc1);

    // Exception beats GPR, R15 and flag writes in the same cycle
    rd_addr[3:0] = 4'd15;
    exc_req = 1; exc_mode = 5'b11011; exc_lr = 32'h77; exc_vector = 32'h4;
    wr_en = 1; wr_addr = 4'd15; wr_data = 32'h999; flags_wr_en = 1; flags_in = 4'h3;
    push(32'h4); push(32'h200);
    #1;
    pop_check("exc_byp_pc", rd1[0 +: W]);
    pop_check("exc_nobyp_pc", rd0[0 +: W]);
    push(32'h4); push(32'h8000_00DB); push(32'h8000_00DF); push(32'h77);
    rd_addr[3:0] = 4'd14;
    tick(); idle();
    pop_check("und_pc", pc1);
    pop_check("und_cpsr", cpsr1);
    pop_check("und_spsr", spsr1);
    pop_check("und_r14", rd1[0 +: W]);

    // Reset discards a concurrent exception entry
    reset = 0;
    exc_req = 1; exc_mode = 5'b10001; exc_lr = 32'h5; exc_vector = 32'h6;
    push(32'hD3); push(32'h0); push(32'h0); push(32'h0);
    tick(); idle();
    pop_check("rst_exc_cpsr", cpsr1);
    pop_check("rst_exc_pc", pc1);
    pop_check("rst_exc_spsr", spsr1);
    pop_check("rst_exc_r14", rd1[0 +: W]);
    reset = 1;
    tick();

    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
